// File: rtl/cutoff_voice_scheduler.sv
// Shares one cutoff exponential lookup across all voices: sweeps active voices on each
// sample tick and squeezes NOTE_ON priority refreshes in between sweeps.
module cutoff_voice_scheduler #(
    parameter int unsigned NUM_VOICES  = 8,
    parameter int unsigned VIDX_W      = 3,
    parameter int unsigned TBL_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SAMPLE_TICK,
    input  logic [NUM_VOICES-1:0]      VOICE_ACTIVE,
    input  logic [NUM_VOICES-1:0]      NOTE_ON,
    input  logic [7*NUM_VOICES-1:0]    VOICE_FREQ_ALL,
    input  logic [6:0]                 CUTOFF_CC,
    input  logic [6:0]                 KEYTRACK_CC,
    output logic [6:0]                 TBL_CUTOFF_CC,
    output logic [6:0]                 TBL_KEYTRACK_CC,
    output logic [6:0]                 TBL_VOICE_FREQ,
    input  logic [14:0]                TBL_CUTOFF_EXP,
    output logic [15*NUM_VOICES-1:0]   CUTOFF_EXP_ALL,
    output logic [NUM_VOICES-1:0]      CUTOFF_VALID,
    output logic                       UPDATE_STROBE,
    output logic [VIDX_W-1:0]          UPDATE_VOICE,
    output logic                       SWEEP_BUSY,
    output logic                       SWEEP_DONE,
    output logic                       OVERRUN
);

    localparam int unsigned CntW = (TBL_LATENCY < 2) ? 1 : $clog2(TBL_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                  state;
    logic [NUM_VOICES-1:0]   remaining;
    logic [NUM_VOICES-1:0]   note_pend;
    logic                    sweep_pend;
    logic                    single;
    logic [CntW-1:0]         wait_cnt;
    logic [VIDX_W-1:0]       cur;
    logic [14:0]             slot [NUM_VOICES];

    logic [6:0]              freq_arr [NUM_VOICES];
    logic [NUM_VOICES-1:0]   cur_mask;
    logic [NUM_VOICES-1:0]   np_mask;
    logic [NUM_VOICES-1:0]   rem_after;
    logic [NUM_VOICES-1:0]   note_clr;
    logic [VIDX_W-1:0]       tick_idx;
    logic [VIDX_W-1:0]       np_idx;
    logic [VIDX_W-1:0]       next_idx;
    logic                    capture;

    function automatic logic [VIDX_W-1:0] lowest(input logic [NUM_VOICES-1:0] m);
        logic [VIDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
            if (m[i]) idx = VIDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            freq_arr[i]                = VOICE_FREQ_ALL[7*i +: 7];
            CUTOFF_EXP_ALL[15*i +: 15] = slot[i];
        end
    end

    always_comb begin
        tick_idx         = lowest(VOICE_ACTIVE);
        np_idx           = lowest(note_pend);
        cur_mask         = '0;
        cur_mask[cur]    = 1'b1;
        np_mask          = '0;
        np_mask[np_idx]  = 1'b1;
        capture          = (state == StWait) && (wait_cnt == CntW'(1));
        rem_after        = remaining & ~cur_mask;
        next_idx         = lowest(rem_after);
        note_clr         = capture ? cur_mask : '0;
    end

    assign SWEEP_BUSY = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= StIdle;
            remaining       <= '0;
            note_pend       <= '0;
            sweep_pend      <= 1'b0;
            single          <= 1'b0;
            wait_cnt        <= '0;
            cur             <= '0;
            TBL_CUTOFF_CC   <= '0;
            TBL_KEYTRACK_CC <= '0;
            TBL_VOICE_FREQ  <= '0;
            CUTOFF_VALID    <= '0;
            UPDATE_STROBE   <= 1'b0;
            UPDATE_VOICE    <= '0;
            SWEEP_DONE      <= 1'b0;
            OVERRUN         <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) slot[i] <= '0;
        end else begin
            UPDATE_STROBE <= 1'b0;
            SWEEP_DONE    <= 1'b0;
            // A NOTE_ON landing on the clearing edge wins, so the voice is serviced again.
            note_pend     <= (note_pend & ~note_clr) | NOTE_ON;

            if (SAMPLE_TICK && state != StIdle) begin
                if (sweep_pend) OVERRUN <= 1'b1;
                else            sweep_pend <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (SAMPLE_TICK || sweep_pend) begin
                        sweep_pend      <= 1'b0;
                        single          <= 1'b0;
                        remaining       <= VOICE_ACTIVE;
                        TBL_CUTOFF_CC   <= CUTOFF_CC;
                        TBL_KEYTRACK_CC <= KEYTRACK_CC;
                        if (VOICE_ACTIVE == '0) begin
                            state      <= StDone;
                            SWEEP_DONE <= 1'b1;
                        end else begin
                            cur            <= tick_idx;
                            TBL_VOICE_FREQ <= freq_arr[tick_idx];
                            state          <= StIssue;
                        end
                    end else if (note_pend != '0) begin
                        single          <= 1'b1;
                        remaining       <= np_mask;
                        TBL_CUTOFF_CC   <= CUTOFF_CC;
                        TBL_KEYTRACK_CC <= KEYTRACK_CC;
                        cur             <= np_idx;
                        TBL_VOICE_FREQ  <= freq_arr[np_idx];
                        state           <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt <= CntW'(TBL_LATENCY);
                    state    <= StWait;
                end
                StWait: begin
                    if (capture) begin
                        slot[cur]         <= TBL_CUTOFF_EXP;
                        CUTOFF_VALID[cur] <= 1'b1;
                        UPDATE_STROBE     <= 1'b1;
                        UPDATE_VOICE      <= cur;
                        remaining         <= rem_after;
                        if (rem_after != '0) begin
                            cur            <= next_idx;
                            TBL_VOICE_FREQ <= freq_arr[next_idx];
                            state          <= StIssue;
                        end else if (single) begin
                            state <= StIdle;
                        end else begin
                            state      <= StDone;
                            SWEEP_DONE <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CntW'(1);
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cutoff_voice_scheduler.sv
// Directed bench for cutoff_voice_scheduler with a registered lookup model and an
// update scoreboard checked on every UPDATE_STROBE.
module tb_cutoff_voice_scheduler;

    logic         clk;
    logic         rst;
    logic         SAMPLE_TICK;
    logic [7:0]   VOICE_ACTIVE;
    logic [7:0]   NOTE_ON;
    logic [55:0]  VOICE_FREQ_ALL;
    logic [6:0]   CUTOFF_CC;
    logic [6:0]   KEYTRACK_CC;
    logic [6:0]   TBL_CUTOFF_CC;
    logic [6:0]   TBL_KEYTRACK_CC;
    logic [6:0]   TBL_VOICE_FREQ;
    logic [14:0]  tbl_q;
    logic [119:0] CUTOFF_EXP_ALL;
    logic [7:0]   CUTOFF_VALID;
    logic         UPDATE_STROBE;
    logic [2:0]   UPDATE_VOICE;
    logic         SWEEP_BUSY;
    logic         SWEEP_DONE;
    logic         OVERRUN;

    typedef struct packed {
        logic [2:0]  v;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;
    int   strobes;
    int   dones;

    cutoff_voice_scheduler #(
        .NUM_VOICES  (8),
        .VIDX_W      (3),
        .TBL_LATENCY (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .SAMPLE_TICK     (SAMPLE_TICK),
        .VOICE_ACTIVE    (VOICE_ACTIVE),
        .NOTE_ON         (NOTE_ON),
        .VOICE_FREQ_ALL  (VOICE_FREQ_ALL),
        .CUTOFF_CC       (CUTOFF_CC),
        .KEYTRACK_CC     (KEYTRACK_CC),
        .TBL_CUTOFF_CC   (TBL_CUTOFF_CC),
        .TBL_KEYTRACK_CC (TBL_KEYTRACK_CC),
        .TBL_VOICE_FREQ  (TBL_VOICE_FREQ),
        .TBL_CUTOFF_EXP  (tbl_q),
        .CUTOFF_EXP_ALL  (CUTOFF_EXP_ALL),
        .CUTOFF_VALID    (CUTOFF_VALID),
        .UPDATE_STROBE   (UPDATE_STROBE),
        .UPDATE_VOICE    (UPDATE_VOICE),
        .SWEEP_BUSY      (SWEEP_BUSY),
        .SWEEP_DONE      (SWEEP_DONE),
        .OVERRUN         (OVERRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] exp_val(input logic [6:0] cc, input logic [6:0] kt,
                                            input logic [6:0] f);
        return {cc, kt, 1'b1} ^ {f, 8'hA5};
    endfunction

    // One-clock lookup: result valid the cycle after the inputs are presented.
    always @(posedge clk) tbl_q <= exp_val(TBL_CUTOFF_CC, TBL_KEYTRACK_CC, TBL_VOICE_FREQ);

    function automatic logic [6:0] fr(input int v);
        return VOICE_FREQ_ALL[7*v +: 7];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        exp_t e;
        e.v   = 3'(v);
        e.val = exp_val(CUTOFF_CC, KEYTRACK_CC, fr(v));
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (UPDATE_STROBE) begin
            strobes++;
            check("sb_has_entry", 128'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("upd_voice", UPDATE_VOICE, e.v);
                check("slot_val", CUTOFF_EXP_ALL[15*e.v +: 15], e.val);
            end
        end
        if (SWEEP_DONE) dones++;
    endtask

    task automatic run_until_dones(input int target, input string tag);
        int k;
        k = 0;
        while (dones < target && k < 60) begin
            cyc();
            k++;
        end
        check(tag, dones, target);
    endtask

    initial begin
        int s0;
        int d0;
        compared     = 0;
        mismatched   = 0;
        strobes      = 0;
        dones        = 0;
        rst          = 1'b0;
        SAMPLE_TICK  = 1'b0;
        VOICE_ACTIVE = '0;
        NOTE_ON      = '0;
        CUTOFF_CC    = 7'd20;
        KEYTRACK_CC  = 7'd3;
        for (int i = 0; i < 8; i++) VOICE_FREQ_ALL[7*i +: 7] = 7'(i * 13 + 5);

        #3;
        check("rst_busy", SWEEP_BUSY, 0);
        check("rst_valid", CUTOFF_VALID, 0);
        check("rst_slots", CUTOFF_EXP_ALL, 0);
        check("rst_overrun", OVERRUN, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc();

        // Sweep of voices 0 and 2.
        VOICE_ACTIVE = 8'h05;
        push(0);
        push(2);
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        check("t1_busy_c1", SWEEP_BUSY, 1);
        check("t1_freq_c1", TBL_VOICE_FREQ, fr(0));
        cyc();
        cyc();
        check("t1_strobe_c3", UPDATE_STROBE, 1);
        check("t1_freq_c3", TBL_VOICE_FREQ, fr(2));
        cyc();
        cyc();
        check("t1_strobe_c5", UPDATE_STROBE, 1);
        check("t1_done_c5", SWEEP_DONE, 1);
        cyc();
        check("t1_idle_c6", SWEEP_BUSY, 0);
        check("t1_done_c6", SWEEP_DONE, 0);
        check("t1_valid", CUTOFF_VALID, 8'h05);
        for (int i = 0; i < 8; i++) begin
            if (i != 0 && i != 2) check("t1_slot_zero", CUTOFF_EXP_ALL[15*i +: 15], 0);
        end

        // Full sweep with CC changed mid-sweep; latched CC must hold.
        VOICE_ACTIVE = 8'hFF;
        CUTOFF_CC    = 7'd64;
        for (int v = 0; v < 8; v++) push(v);
        d0 = dones;
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        cyc();
        CUTOFF_CC = 7'd10;
        for (int k = 0; k < 40 && dones == d0; k++) begin
            check("t2_cc_hold", TBL_CUTOFF_CC, 64);
            cyc();
        end
        check("t2_done_once", dones - d0, 1);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_valid", CUTOFF_VALID, 8'hFF);
        cyc();

        // NOTE_ON refresh of an inactive voice, no sweep.
        VOICE_ACTIVE = 8'h01;
        s0 = strobes;
        d0 = dones;
        push(5);
        NOTE_ON = 8'h20;
        cyc();
        NOTE_ON = '0;
        repeat (8) cyc();
        check("t4_strobes", strobes - s0, 1);
        check("t4_no_done", dones - d0, 0);
        check("t4_idle", SWEEP_BUSY, 0);
        check("t4_sb_empty", sb.size(), 0);

        // Empty sweep goes straight to DONE.
        VOICE_ACTIVE = '0;
        s0 = strobes;
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        check("t5_done_c1", SWEEP_DONE, 1);
        check("t5_busy_c1", SWEEP_BUSY, 1);
        cyc();
        check("t5_done_c2", SWEEP_DONE, 0);
        check("t5_idle_c2", SWEEP_BUSY, 0);
        check("t5_no_strobe", strobes - s0, 0);

        // One tick during a sweep queues exactly one more sweep.
        VOICE_ACTIVE = 8'h03;
        d0 = dones;
        push(0);
        push(1);
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        cyc();
        push(0);
        push(1);
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        run_until_dones(d0 + 2, "t3a_two_sweeps");
        repeat (6) cyc();
        check("t3a_no_extra", dones - d0, 2);
        check("t3a_overrun", OVERRUN, 0);
        check("t3a_sb_empty", sb.size(), 0);

        // Two ticks during one sweep: overrun, still only one extra sweep.
        d0 = dones;
        push(0);
        push(1);
        push(0);
        push(1);
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        cyc();
        SAMPLE_TICK = 1'b1;
        cyc();
        cyc();
        SAMPLE_TICK = 1'b0;
        run_until_dones(d0 + 2, "t3b_two_sweeps");
        repeat (6) cyc();
        check("t3b_no_extra", dones - d0, 2);
        check("t3b_overrun", OVERRUN, 1);
        check("t3b_sb_empty", sb.size(), 0);

        // Reset in WAIT discards the in-flight lookup.
        VOICE_ACTIVE = 8'h01;
        SAMPLE_TICK = 1'b1;
        cyc();
        SAMPLE_TICK = 1'b0;
        cyc();
        check("t6_busy_wait", SWEEP_BUSY, 1);
        rst = 1'b0;
        #1;
        check("t6_busy", SWEEP_BUSY, 0);
        check("t6_valid", CUTOFF_VALID, 0);
        check("t6_slots", CUTOFF_EXP_ALL, 0);
        check("t6_overrun", OVERRUN, 0);
        check("t6_tbl_cc", TBL_CUTOFF_CC, 0);
        check("t6_tbl_freq", TBL_VOICE_FREQ, 0);
        check("t6_strobe", UPDATE_STROBE, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        s0 = strobes;
        repeat (5) cyc();
        check("t6_no_capture", strobes - s0, 0);
        check("t6_idle_after", SWEEP_BUSY, 0);
        check("t6_valid_after", CUTOFF_VALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
